// File: rtl/trace_arbiter_ctrl_pkg.sv
// Shared types for the trace write arbiter and FIFO drain sequencer.
// Build option TRACE_ARB_DROP_EN turns full-FIFO backpressure into counted drops.
package trace_arb_pkg;

    localparam int DROP_CNT_W      = 32;
    localparam int TRACE_WIDTH_DEF = 64;

    typedef logic [TRACE_WIDTH_DEF-1:0] trace_elem_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/trace_arbiter_ctrl_if.sv
// Bus bundle linking the arbiter to its sources, trace FIFO and sink.
// master is the arbiter side; slave is the surrounding environment.
interface trace_arbiter_ctrl_if #(
    parameter int NUM_SOURCES = 4,
    parameter int TRACE_WIDTH = 64
);
    import trace_arb_pkg::*;

    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [NUM_SOURCES-1:0]             src_valid;
    logic [NUM_SOURCES*TRACE_WIDTH-1:0] src_data;
    logic [NUM_SOURCES-1:0]             src_ready;
    logic                               buf_wr_en;
    logic [TRACE_WIDTH-1:0]             buf_wr_data;
    logic                               buf_full;
    logic                               buf_empty;
    logic                               buf_rd_en;
    logic [TRACE_WIDTH-1:0]             buf_rd_data;
    logic                               drain_enable;
    logic                               sink_valid;
    logic [TRACE_WIDTH-1:0]             sink_data;
    logic                               sink_ready;
    logic [IDX_W-1:0]                   grant_idx;
    logic [DROP_CNT_W-1:0]              drop_count;

    modport master (
        input  src_valid, src_data, buf_full, buf_empty,
        input  buf_rd_data, drain_enable, sink_ready,
        output src_ready, buf_wr_en, buf_wr_data, buf_rd_en,
        output sink_valid, sink_data, grant_idx, drop_count
    );

    modport slave (
        output src_valid, src_data, buf_full, buf_empty,
        output buf_rd_data, drain_enable, sink_ready,
        input  src_ready, buf_wr_en, buf_wr_data, buf_rd_en,
        input  sink_valid, sink_data, grant_idx, drop_count
    );

endinterface

// File: rtl/trace_arbiter_ctrl_rr_arbiter.sv
// Round-robin priority picker: first requester after ptr_i, wrapping.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/trace_arbiter_ctrl.sv
// Round-robin writer into a shared trace FIFO plus a drain FSM to one sink.
// Optional macro TRACE_ARB_DROP_EN: sources never stall, full writes are counted drops.
module trace_arbiter_ctrl
    import trace_arb_pkg::*;
#(
    parameter int NUM_SOURCES     = 4,
    parameter int TRACE_WIDTH     = 64,
    parameter int FIFO_RD_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    trace_arbiter_ctrl_if.master bus
);

    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CNT_W = 2;

    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [NUM_SOURCES-1:0] win_gnt;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   hs;

    rr_arbiter #(
        .N     (NUM_SOURCES),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (bus.src_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

`ifdef TRACE_ARB_DROP_EN
    assign bus.src_ready = win_gnt & {NUM_SOURCES{!rst}};
`else
    assign bus.src_ready = win_gnt & {NUM_SOURCES{!rst && !bus.buf_full}};
`endif

    // A handshake while full is a drop: the pointer still moves on.
    assign hs              = |(bus.src_valid & bus.src_ready);
    assign bus.buf_wr_en   = hs & !bus.buf_full;
    assign bus.buf_wr_data = bus.src_data[win_idx*TRACE_WIDTH +: TRACE_WIDTH];
    assign grant_idx_d     = win_any ? win_idx : grant_idx_q;
    assign bus.grant_idx   = rst ? '0 : grant_idx_d;
    assign rr_ptr_d        = hs ? win_idx : rr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= IDX_W'(NUM_SOURCES-1);
            grant_idx_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

`ifdef TRACE_ARB_DROP_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (hs && bus.buf_full && (drop_q != '1))
            drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = '0;
`endif

    drain_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sink_valid_q, sink_valid_d;
    logic [TRACE_WIDTH-1:0] sink_data_q, sink_data_d;
    logic                   rd_en;
    logic                   more;

    assign more = bus.drain_enable & !bus.buf_empty;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sink_valid_d = sink_valid_q;
        sink_data_d  = sink_data_q;
        rd_en        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (more) begin
                    rd_en   = 1'b1;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == CNT_W'(FIFO_RD_LATENCY-1)) begin
                    sink_data_d  = bus.buf_rd_data;
                    sink_valid_d = 1'b1;
                    state_d      = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.sink_ready) begin
                    sink_valid_d = 1'b0;
                    if (more) begin
                        rd_en   = 1'b1;
                        cnt_d   = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sink_valid_q <= 1'b0;
            sink_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sink_valid_q <= sink_valid_d;
            sink_data_q  <= sink_data_d;
        end
    end

    assign bus.buf_rd_en  = rd_en & !rst;
    assign bus.sink_valid = sink_valid_q;
    assign bus.sink_data  = sink_data_q;

endmodule

// File: tb/tb_trace_arbiter_ctrl.sv
// Bench for trace_arbiter_ctrl: FIFO model, rule-level reference, random traffic.
// Works with or without TRACE_ARB_DROP_EN defined.
module tb_trace_arbiter_ctrl;
    import trace_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 64;
    localparam int LAT   = 1;
    localparam int DEPTH = 16;
`ifdef TRACE_ARB_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic force_full  = 1'b0;
    logic fifo_full_r = 1'b0;

    trace_arbiter_ctrl_if #(.NUM_SOURCES(N), .TRACE_WIDTH(W)) bus ();

    trace_arbiter_ctrl #(
        .NUM_SOURCES     (N),
        .TRACE_WIDTH     (W),
        .FIFO_RD_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.buf_full = force_full | fifo_full_r;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    trace_elem_t fifo[$];
    trace_elem_t exp_q[$];
    trace_elem_t pre_q[$];
    trace_elem_t acc_log[$];
    int          acc_cyc[$];
    int          gl[$];

    int          m_ptr, m_glast, m_infl, m_age;
    logic [31:0] m_drop;
    trace_elem_t held;
    bit          held_v;
    bit          rec_wr, rec_rd;
    trace_elem_t rec_wr_data;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic int win(input int p, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(p+k)%N]) return (p+k)%N;
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    // FIFO model with one-cycle read latency, fed from the negedge samples
    always @(posedge clk) begin
        #1;
        if (rst) begin
            fifo.delete();
            exp_q.delete();
        end else begin
            if (rec_rd && fifo.size() > 0) bus.buf_rd_data = fifo.pop_front();
            if (rec_wr) begin
                fifo.push_back(rec_wr_data);
                exp_q.push_back(rec_wr_data);
            end
            while (pre_q.size() > 0) begin
                trace_elem_t x;
                x = pre_q.pop_front();
                fifo.push_back(x);
                exp_q.push_back(x);
            end
        end
        bus.buf_empty = (fifo.size() == 0);
        fifo_full_r   = (fifo.size() >= DEPTH);
    end

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        int             w, eg;
        logic [N-1:0]   er;
        bit             full, ew, evalid, erd, acc;
        trace_elem_t    ed;
        if (rst) begin
            m_ptr = N-1; m_glast = 0; m_infl = 0; m_age = 0;
            m_drop = '0; held_v = 0; rec_wr = 0; rec_rd = 0;
            chk(bus.src_ready == '0 && !bus.buf_wr_en && !bus.buf_rd_en
                && !bus.sink_valid, "reset_outs",
                {bus.src_ready, bus.buf_wr_en, bus.buf_rd_en, bus.sink_valid}, 0);
        end else begin
            full = bus.buf_full;
            w    = win(m_ptr, bus.src_valid);
            eg   = (w >= 0) ? w : m_glast;
            er   = '0;
            if (w >= 0 && (DROP || !full)) er[w] = 1'b1;
            ew = (w >= 0) && !full;
            chk(bus.src_ready == er, "src_ready", bus.src_ready, er);
            chk(bus.buf_wr_en == ew, "wr_en", bus.buf_wr_en, ew);
            chk(int'(bus.grant_idx) == eg, "grant_idx", bus.grant_idx, eg);
            if (ew)
                chk(bus.buf_wr_data == bus.src_data[w*W +: W], "wr_data",
                    bus.buf_wr_data, bus.src_data[w*W +: W]);
            chk(bus.drop_count == m_drop, "drop_count", bus.drop_count, m_drop);
            evalid = (m_infl != 0) && (m_age >= LAT);
            chk(bus.sink_valid == evalid, "sink_valid", bus.sink_valid, evalid);
            if (held_v)
                chk(bus.sink_data == held, "sink_hold", bus.sink_data, held);
            acc = evalid && bus.sink_ready;
            erd = bus.drain_enable && !bus.buf_empty && (m_infl == 0 || acc);
            chk(bus.buf_rd_en == erd, "rd_en", bus.buf_rd_en, erd);
            if (bus.sink_valid && bus.sink_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "sink_unexpected", bus.sink_data, 0);
                end else begin
                    ed = exp_q.pop_front();
                    chk(bus.sink_data == ed, "sink_data", bus.sink_data, ed);
                    acc_log.push_back(bus.sink_data);
                    acc_cyc.push_back(cyc);
                end
            end
            if (bus.buf_wr_en) gl.push_back(int'(bus.grant_idx));
            held_v = bus.sink_valid && !bus.sink_ready;
            held   = bus.sink_data;
            if (w >= 0 && (DROP || !full)) m_ptr = w;
            if (w >= 0 && full && DROP && m_drop != '1) m_drop++;
            m_glast = eg;
            if (acc) m_infl = 0;
            if (erd) begin
                m_infl = 1;
                m_age  = 0;
            end else if (m_infl != 0) begin
                m_age++;
            end
            rec_wr      = bus.buf_wr_en;
            rec_wr_data = bus.buf_wr_data;
            rec_rd      = bus.buf_rd_en;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain_all(input string nm);
        int k;
        k = 0;
        bus.src_valid    = '0;
        bus.drain_enable = 1'b1;
        bus.sink_ready   = 1'b1;
        force_full       = 1'b0;
        while ((fifo.size() != 0 || bus.sink_valid || m_infl != 0) && k < 200) begin
            step(1);
            k++;
        end
        chk(k < 200, nm, k, 200);
        step(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst              = 1'b1;
        bus.src_valid    = '0;
        bus.src_data     = '0;
        bus.drain_enable = 1'b0;
        bus.sink_ready   = 1'b0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk(bus.grant_idx == 0, "rst_grant", bus.grant_idx, 0);
        chk(bus.drop_count == 0, "rst_drop", bus.drop_count, 0);
        chk(bus.sink_data == 0, "rst_sink_data", bus.sink_data, 0);
        step(1);

        // all sources valid: strict rotation from index 0
        for (int i = 0; i < N; i++) bus.src_data[i*W +: W] = 64'hC0 + 64'(i);
        gl.delete();
        bus.src_valid = '1;
        step(6);
        bus.src_valid = '0;
        chk(gl.size() == 6, "t1_count", gl.size(), 6);
        for (int j = 0; j < 6 && j < gl.size(); j++)
            chk(gl[j] == j % 4, "t1_order", gl[j], j % 4);
        drain_all("t1_drain_timeout");

        // source 2 alone, then source 0 joins
        gl.delete();
        bus.src_valid = 4'b0100;
        step(1);
        bus.src_valid = 4'b0101;
        step(3);
        bus.src_valid = '0;
        chk(gl.size() == 4, "t2_count", gl.size(), 4);
        if (gl.size() == 4) begin
            chk(gl[0] == 2, "t2_g0", gl[0], 2);
            chk(gl[1] == 0, "t2_g1", gl[1], 0);
            chk(gl[2] == 2, "t2_g2", gl[2], 2);
            chk(gl[3] == 0, "t2_g3", gl[3], 0);
        end
        drain_all("t2_drain_timeout");

        // FIFO full for 5 cycles with sources 1 and 3 pending
        gl.delete();
        force_full    = 1'b1;
        bus.src_valid = 4'b1010;
        step(5);
        chk(gl.size() == 0, "t3_no_write_full", gl.size(), 0);
        force_full = 1'b0;
        step(1);
        bus.src_valid = '0;
        chk(gl.size() == 1, "t3_count", gl.size(), 1);
`ifdef TRACE_ARB_DROP_EN
        if (gl.size() > 0) chk(gl[0] == 3, "t3_first", gl[0], 3);
        @(negedge clk);
        chk(bus.drop_count == 5, "t3_drops", bus.drop_count, 5);
`else
        if (gl.size() > 0) chk(gl[0] == 1, "t3_first", gl[0], 1);
        @(negedge clk);
        chk(bus.drop_count == 0, "t3_drops", bus.drop_count, 0);
`endif
        drain_all("t3_drain_timeout");

        // preloaded FIFO drains at one element per two cycles
        acc_log.delete();
        acc_cyc.delete();
        pre_q.push_back(64'hA1);
        pre_q.push_back(64'hA2);
        pre_q.push_back(64'hA3);
        step(12);
        chk(acc_log.size() == 3, "t4_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk(acc_log[0] == 64'hA1, "t4_d0", acc_log[0], 64'hA1);
            chk(acc_log[1] == 64'hA2, "t4_d1", acc_log[1], 64'hA2);
            chk(acc_log[2] == 64'hA3, "t4_d2", acc_log[2], 64'hA3);
            chk(acc_cyc[1] - acc_cyc[0] == 2, "t4_gap0", acc_cyc[1] - acc_cyc[0], 2);
            chk(acc_cyc[2] - acc_cyc[1] == 2, "t4_gap1", acc_cyc[2] - acc_cyc[1], 2);
        end
        chk(!bus.sink_valid, "t4_idle", bus.sink_valid, 0);

        // sink stalls four cycles while 0xB7 is held
        bus.sink_ready = 1'b0;
        pre_q.push_back(64'hB7);
        pre_q.push_back(64'hB8);
        k = 0;
        while (!bus.sink_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(k < 20, "t5_valid_timeout", k, 20);
        for (int j = 0; j < 4; j++) begin
            chk(bus.sink_valid, "t5_valid", bus.sink_valid, 1);
            chk(bus.sink_data == 64'hB7, "t5_data", bus.sink_data, 64'hB7);
            chk(!bus.buf_rd_en, "t5_no_rd", bus.buf_rd_en, 0);
            @(negedge clk);
        end
        step(1);
        drain_all("t5_drain_timeout");

        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.src_valid = N'($urandom);
            for (int i = 0; i < N; i++) bus.src_data[i*W +: W] = {$urandom, $urandom};
            bus.drain_enable = ($urandom % 4) != 0;
            bus.sink_ready   = ($urandom % 3) != 0;
            force_full       = ($urandom % 8) == 0;
            step(1);
        end
        drain_all("rand_drain_timeout");

        // asynchronous reset during FETCH
        for (int i = 0; i < N; i++) bus.src_data[i*W +: W] = 64'hE0 + 64'(i);
        pre_q.push_back(64'hC1);
        k = 0;
        while (!bus.buf_rd_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(k < 20, "t7_rd_timeout", k, 20);
        @(posedge clk);
        #3;
        bus.src_valid = '1;
        #1;
        rst = 1'b1;
        #1;
        chk(bus.src_ready == '0, "t7_src_ready", bus.src_ready, 0);
        chk(!bus.buf_rd_en, "t7_rd_en", bus.buf_rd_en, 0);
        chk(!bus.sink_valid, "t7_sink_valid", bus.sink_valid, 0);
        chk(!bus.buf_wr_en, "t7_wr_en", bus.buf_wr_en, 0);
        step(2);
        rst           = 1'b0;
        bus.src_valid = 4'b1001;
        @(negedge clk);
        chk(bus.grant_idx == 0, "t7_rr_ptr", bus.grant_idx, 0);
        chk(!bus.sink_valid, "t7_idle", bus.sink_valid, 0);
        step(1);
        drain_all("t7_drain_timeout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
